// File: rtl/fp_normalize_round.sv
// rtl/fp_normalize_round.sv - multi-cycle normalize, round-to-nearest-even and pack to IEEE-754 single
// Shifts one bit per cycle until the leading one sits at bit 46, then rounds and classifies in one edge.
module fp_normalize_round (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sign_in,
  input  logic [9:0]  exp_in,
  input  logic [48:0] mant_in,
  input  logic [5:0]  msb_loc,
  output logic [31:0] result,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        underflow
);

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND} state_t;

  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  logic signed [11:0] exp_q, exp_d;
  logic [48:0]        mant_q, mant_d;
  logic [5:0]         k_q, k_d;
  logic               right_q, right_d;
  logic               sticky_q, sticky_d;
  logic               zero_q, zero_d;
  logic [31:0]        result_q, result_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  logic               mant_zero;
  logic               shift_right;
  logic [5:0]         k_in;
  logic [22:0]        frac;
  logic               guard;
  logic               sticky_all;
  logic               round_up;
  logic [23:0]        frac_sum;
  logic signed [11:0] exp_r;

  assign mant_zero   = (mant_in == 49'd0);
  assign shift_right = (msb_loc > 6'd46);
  // A zero mantissa has no meaningful leading one, so it skips the shifter entirely.
  assign k_in = mant_zero   ? 6'd0 :
                shift_right ? (msb_loc - 6'd46) : (6'd46 - msb_loc);

  assign frac       = mant_q[45:23];
  assign guard      = mant_q[22];
  assign sticky_all = (|mant_q[21:0]) | sticky_q;
  assign round_up   = guard & (sticky_all | frac[0]);
  assign frac_sum   = {1'b0, frac} + {23'd0, round_up};
  assign exp_r      = exp_q + {11'd0, frac_sum[23]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      k_q      <= '0;
      right_q  <= 1'b0;
      sticky_q <= 1'b0;
      zero_q   <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      k_q      <= k_d;
      right_q  <= right_d;
      sticky_q <= sticky_d;
      zero_q   <= zero_d;
      result_q <= result_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (k_in != 6'd0) ? SHIFT : ROUND;
      SHIFT:   if (k_q == 6'd1) state_d = ROUND;
      ROUND:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    k_d      = k_q;
    right_d  = right_q;
    sticky_d = sticky_q;
    zero_d   = zero_q;
    result_d = result_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sign_d   = sign_in;
          exp_d    = {{2{exp_in[9]}}, exp_in};
          mant_d   = mant_in;
          k_d      = k_in;
          right_d  = shift_right;
          sticky_d = 1'b0;
          zero_d   = mant_zero;
        end
      end
      SHIFT: begin
        if (right_q) begin
          mant_d   = mant_q >> 1;
          exp_d    = exp_q + 12'sd1;
          sticky_d = sticky_q | mant_q[0];
        end else begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - 12'sd1;
        end
        k_d = k_q - 6'd1;
      end
      ROUND: begin
        done_d = 1'b1;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        if (zero_q) begin
          result_d = {sign_q, 31'd0};
        end else if (exp_r >= 12'sd255) begin
          result_d = {sign_q, 8'hFF, 23'd0};
          ovf_d    = 1'b1;
        end else if (exp_r <= 12'sd0) begin
          result_d = {sign_q, 31'd0};
          unf_d    = 1'b1;
        end else begin
          result_d = {sign_q, exp_r[7:0], frac_sum[22:0]};
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    done      = done_q;
    result    = result_q;
    overflow  = ovf_q;
    underflow = unf_q;
  end

endmodule

// File: tb/tb_fp_normalize_round.sv
// tb/tb_fp_normalize_round.sv - scoreboard bench for fp_normalize_round
// Expected results and done cycles are queued at start and retired on each done pulse.
module tb_fp_normalize_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sign_in;
  logic [9:0]  exp_in;
  logic [48:0] mant_in;
  logic [5:0]  msb_loc;
  logic [31:0] result;
  logic        busy;
  logic        done;
  logic        overflow;
  logic        underflow;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  fp_normalize_round dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sign_in  (sign_in),
    .exp_in   (exp_in),
    .mant_in  (mant_in),
    .msb_loc  (msb_loc),
    .result   (result),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", 64'(result), 64'(e.res));
        check("overflow", 64'(overflow), 64'(e.ovf));
        check("underflow", 64'(underflow), 64'(e.unf));
        check("done_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  // Called at a negedge; start is seen at the following rising edge.
  task automatic drive(input logic s, input logic [9:0] e, input logic [48:0] m,
                       input logic [5:0] loc, input logic [31:0] res,
                       input logic ovf, input logic unf, input bit push);
    exp_t x;
    int   k;
    if (m == 49'd0)       k = 0;
    else if (loc > 6'd46) k = int'(loc) - 46;
    else                  k = 46 - int'(loc);
    sign_in = s; exp_in = e; mant_in = m; msb_loc = loc;
    start   = 1'b1;
    if (push) begin
      x.res = res; x.ovf = ovf; x.unf = unf; x.due = cyc + k + 2;
      sb.push_back(x);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) ok = 1'b1;
    end
    if (!ok) check("idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input logic s, input logic [9:0] e, input logic [48:0] m,
                        input logic [5:0] loc, input logic [31:0] res,
                        input logic ovf, input logic unf);
    wait_idle();
    drive(s, e, m, loc, res, ovf, unf, 1'b1);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; start = 1'b0; sign_in = 1'b0; exp_in = '0; mant_in = '0; msb_loc = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_unf", 64'(underflow), 64'd0);
    rst = 1'b0;

    run_op(1'b0, 10'd127, 49'd1 << 46, 6'd46, 32'h3F800000, 1'b0, 1'b0);
    run_op(1'b0, 10'd127, 49'd1 << 48, 6'd48, 32'h40800000, 1'b0, 1'b0);
    run_op(1'b0, 10'd133, 49'd1 << 40, 6'd40, 32'h3F800000, 1'b0, 1'b0);
    run_op(1'b0, 10'd127, (49'd1 << 46) | (49'd1 << 22), 6'd46, 32'h3F800000, 1'b0, 1'b0);
    run_op(1'b0, 10'd127, (49'd1 << 46) | (49'd1 << 23) | (49'd1 << 22), 6'd46,
           32'h3F800002, 1'b0, 1'b0);
    run_op(1'b0, 10'd127, (49'd1 << 47) - (49'd1 << 22), 6'd46, 32'h40000000, 1'b0, 1'b0);
    run_op(1'b0, 10'd127, (49'd1 << 48) | (49'd1 << 24) | 49'd1, 6'd48,
           32'h40800001, 1'b0, 1'b0);
    run_op(1'b0, 10'd254, 49'd1 << 48, 6'd48, 32'h7F800000, 1'b1, 1'b0);
    run_op(1'b0, 10'd1, 49'd1 << 45, 6'd45, 32'h00000000, 1'b0, 1'b1);
    run_op(1'b1, 10'd127, 49'd0, 6'd0, 32'h80000000, 1'b0, 1'b0);
    run_op(1'b1, 10'd173, 49'd1, 6'd0, 32'hBF800000, 1'b0, 1'b0);
    run_op(1'b1, 10'h3F6, 49'd1 << 48, 6'd48, 32'h80000000, 1'b0, 1'b1);

    // Start pulsed mid-shift must not disturb the operation in flight.
    run_op(1'b0, 10'd133, 49'd1 << 40, 6'd40, 32'h3F800000, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("busy_in_shift", 64'(busy), 64'd1);
    drive(1'b1, 10'd200, 49'd1 << 46, 6'd46, 32'h0, 1'b0, 1'b0, 1'b0);

    // Reset mid-shift aborts without a done pulse.
    wait_idle();
    drive(1'b0, 10'd133, 49'd1 << 40, 6'd40, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    repeat (12) @(negedge clk);
    check("abort_idle", 64'(busy), 64'd0);

    // Back-to-back: second start issued in the done cycle of the first.
    run_op(1'b0, 10'd127, 49'd1 << 48, 6'd48, 32'h40800000, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("b2b_done_seen", 64'(seen), 64'd1);
    drive(1'b1, 10'd133, 49'd1 << 40, 6'd40, 32'hBF800000, 1'b0, 1'b0, 1'b1);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
